// File: rtl/bht_ram_arbiter.sv
// bht_ram_arbiter: single-port SRAM arbiter/sequencer for one branch-predictor table.
// Shares the RAM port between the frontend lookup, the commit-side update and an
// init/flush sweep that writes INIT_VAL to every row.
// Optional feature macro: BHT_ARB_DROP_CNT_EN adds drop_cnt_o, a saturating count of
// updates dropped while a sweep is running.
module bht_ram_arbiter #(
    parameter int                 NR_ROWS      = 64,
    parameter int                 DATA_W       = 4,
    parameter logic [DATA_W-1:0]  INIT_VAL     = DATA_W'(4'b0101),
    parameter int                 STARVE_LIMIT = 4,
    parameter int                 ROW_BITS     = $clog2(NR_ROWS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_bp_i,
    input  logic                debug_mode_i,
    input  logic                lookup_req_i,
    input  logic [ROW_BITS-1:0] lookup_row_i,
    output logic                lookup_ready_o,
    output logic                lookup_rvalid_o,
    output logic [DATA_W-1:0]   lookup_rdata_o,
    input  logic                update_req_i,
    input  logic [ROW_BITS-1:0] update_row_i,
    input  logic [DATA_W-1:0]   update_wdata_i,
    output logic                update_ready_o,
    output logic                ram_req_o,
    output logic                ram_we_o,
    output logic [ROW_BITS-1:0] ram_addr_o,
    output logic [DATA_W-1:0]   ram_wdata_o,
    input  logic [DATA_W-1:0]   ram_rdata_i,
    output logic                busy_o
`ifdef BHT_ARB_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_FLUSH
    } state_e;

    localparam logic [ROW_BITS-1:0] LAST_ROW   = ROW_BITS'(NR_ROWS - 1);
    localparam logic [3:0]          STARVE_MAX = 4'(STARVE_LIMIT);

    state_e              state_q, state_d;
    logic [ROW_BITS-1:0] sweep_q, sweep_d;
    logic [3:0]          starve_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_hold_q;

    logic sweeping;
    logic last_row;
    logic upd_valid;
    logic force_lookup;
    logic grant_upd;
    logic grant_lkp;

    // Arbitration decision: update beats lookup unless the lookup has starved long enough.
    assign sweeping     = (state_q != ST_RUN);
    assign last_row     = (sweep_q == LAST_ROW);
    assign upd_valid    = update_req_i && !debug_mode_i;
    assign force_lookup = lookup_req_i && (starve_q == STARVE_MAX);
    assign grant_upd    = !sweeping && !flush_bp_i && upd_valid && !force_lookup;
    assign grant_lkp    = !sweeping && !flush_bp_i && lookup_req_i && (!upd_valid || force_lookup);

    // State and sweep row register; reset always restarts the init sweep from row 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Next state: sweeps run to the last row (restarting on flush), RUN leaves on flush.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_INIT, ST_FLUSH: begin
                if (flush_bp_i) begin
                    sweep_d = '0;
                end else if (last_row) begin
                    sweep_d = '0;
                    state_d = ST_RUN;
                end else begin
                    sweep_d = sweep_q + ROW_BITS'(1);
                end
            end
            ST_RUN: begin
                if (flush_bp_i) begin
                    state_d = ST_FLUSH;
                    sweep_d = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = '0;
            end
        endcase
    end

    // RAM port and handshake outputs, all combinational from state and requests.
    always_comb begin
        ram_req_o      = 1'b0;
        ram_we_o       = 1'b0;
        ram_addr_o     = '0;
        ram_wdata_o    = '0;
        lookup_ready_o = grant_lkp;
        update_ready_o = !sweeping && !flush_bp_i && update_req_i && (debug_mode_i || grant_upd);
        busy_o         = sweeping;
        if (sweeping) begin
            ram_req_o   = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = sweep_q;
            ram_wdata_o = INIT_VAL;
        end else if (grant_upd) begin
            ram_req_o   = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = update_row_i;
            ram_wdata_o = update_wdata_i;
        end else if (grant_lkp) begin
            ram_req_o   = 1'b1;
            ram_addr_o  = lookup_row_i;
        end
    end

    // Starvation counter: counts consecutive denied lookups, saturating at the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else if (sweeping) begin
            starve_q <= '0;
        end else if (lookup_req_i && !grant_lkp) begin
            if (starve_q != STARVE_MAX) begin
                starve_q <= starve_q + 4'd1;
            end
        end else begin
            starve_q <= '0;
        end
    end

    // Read return: valid one cycle after a lookup grant; data is held once captured.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q     <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            rvalid_q <= grant_lkp;
            if (rvalid_q) begin
                rdata_hold_q <= ram_rdata_i;
            end
        end
    end

    assign lookup_rvalid_o = rvalid_q;
    assign lookup_rdata_o  = rvalid_q ? ram_rdata_i : rdata_hold_q;

`ifdef BHT_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    // Count valid updates lost to a sweep; debug-swallowed updates are not drops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else if (sweeping && upd_valid && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bht_ram_arbiter.sv
// tb_bht_ram_arbiter: randomized self-checking bench for bht_ram_arbiter with a
// behavioural RAM and a high-level reference model (phase, rows left, lost lookups).
module tb_bht_ram_arbiter;

    localparam int NR_ROWS      = 64;
    localparam int DATA_W       = 4;
    localparam int STARVE_LIMIT = 4;
    localparam int ROW_BITS     = 6;
    localparam logic [3:0] INIT_VAL = 4'b0101;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                flush_bp = 1'b0;
    logic                debug_mode = 1'b0;
    logic                lookup_req = 1'b0;
    logic [ROW_BITS-1:0] lookup_row = '0;
    logic                lookup_ready;
    logic                lookup_rvalid;
    logic [DATA_W-1:0]   lookup_rdata;
    logic                update_req = 1'b0;
    logic [ROW_BITS-1:0] update_row = '0;
    logic [DATA_W-1:0]   update_wdata = '0;
    logic                update_ready;
    logic                ram_req;
    logic                ram_we;
    logic [ROW_BITS-1:0] ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata = '0;
    logic                busy;
`ifdef BHT_ARB_DROP_CNT_EN
    logic [15:0]         drop_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          m_sweep;
    int          m_row;
    int          m_lost;
    bit          m_pend;
    logic [3:0]  m_pend_data;
    logic [3:0]  m_last;
    int          m_drop;
    logic [3:0]  shadow [NR_ROWS];

    // Behavioural RAM
    logic [3:0]  mem [NR_ROWS];

    bht_ram_arbiter #(
        .NR_ROWS(NR_ROWS),
        .DATA_W(DATA_W),
        .INIT_VAL(INIT_VAL),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .flush_bp_i(flush_bp),
        .debug_mode_i(debug_mode),
        .lookup_req_i(lookup_req),
        .lookup_row_i(lookup_row),
        .lookup_ready_o(lookup_ready),
        .lookup_rvalid_o(lookup_rvalid),
        .lookup_rdata_o(lookup_rdata),
        .update_req_i(update_req),
        .update_row_i(update_row),
        .update_wdata_i(update_wdata),
        .update_ready_o(update_ready),
        .ram_req_o(ram_req),
        .ram_we_o(ram_we),
        .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata),
        .busy_o(busy)
`ifdef BHT_ARB_DROP_CNT_EN
        ,
        .drop_cnt_o(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_req) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_sweep = 1'b1;
        m_row   = 0;
        m_lost  = 0;
        m_pend  = 1'b0;
        m_last  = '0;
        m_drop  = 0;
    endfunction

    // Hold reset for a few cycles, check reset values, release away from an edge
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        lookup_req = 1'b0; update_req = 1'b0; flush_bp = 1'b0; debug_mode = 1'b0;
        #1;
        check_output("rst_busy",   busy, 1);
        check_output("rst_lready", lookup_ready, 0);
        check_output("rst_uready", update_ready, 0);
        check_output("rst_rvalid", lookup_rvalid, 0);
        check_output("rst_rdata",  lookup_rdata, 0);
`ifdef BHT_ARB_DROP_CNT_EN
        check_output("rst_drop",   drop_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One cycle: drive inputs, compare against the model, then advance the model
    task automatic apply_stimulus(input bit lreq, input int lrow, input bit ureq, input int urow,
                                  input logic [3:0] wd, input bit dbg, input bit fl);
        bit         e_req, e_we, e_lr, e_ur, win_u, win_l;
        int         e_addr;
        logic [3:0] e_wd;
        @(negedge clk);
        lookup_req   = lreq;
        lookup_row   = 6'(lrow);
        update_req   = ureq;
        update_row   = 6'(urow);
        update_wdata = wd;
        debug_mode   = dbg;
        flush_bp     = fl;
        #1;
        e_req = 0; e_we = 0; e_lr = 0; e_ur = 0; win_u = 0; win_l = 0; e_addr = 0; e_wd = '0;
        if (m_sweep) begin
            e_req = 1; e_we = 1; e_addr = m_row; e_wd = INIT_VAL;
        end else if (!fl) begin
            win_u = ureq && !dbg && !(m_lost == STARVE_LIMIT && lreq);
            win_l = lreq && !win_u;
            e_ur  = ureq && (dbg || win_u);
            e_lr  = win_l;
            if (win_u) begin
                e_req = 1; e_we = 1; e_addr = urow; e_wd = wd;
            end else if (win_l) begin
                e_req = 1; e_addr = lrow;
            end
        end
        check_output("ram_req", ram_req, e_req);
        if (e_req) begin
            check_output("ram_we",   ram_we, e_we);
            check_output("ram_addr", ram_addr, e_addr);
        end
        if (e_we) check_output("ram_wdata", ram_wdata, e_wd);
        check_output("lookup_ready", lookup_ready, e_lr);
        check_output("update_ready", update_ready, e_ur);
        check_output("busy",         busy, m_sweep);
        check_output("rvalid",       lookup_rvalid, m_pend);
        check_output("rdata",        lookup_rdata, m_pend ? m_pend_data : m_last);
`ifdef BHT_ARB_DROP_CNT_EN
        check_output("drop_cnt",     drop_cnt, m_drop);
`endif
        @(posedge clk);
        if (m_pend) m_last = m_pend_data;
        m_pend = win_l;
        if (win_l) m_pend_data = shadow[lrow];
        if (win_u) shadow[urow] = wd;
        if (m_sweep) begin
            shadow[m_row] = INIT_VAL;
            if (ureq && !dbg && m_drop < 16'hFFFF) m_drop++;
            m_lost = 0;
            if (fl)                       m_row = 0;
            else if (m_row == NR_ROWS-1) begin m_sweep = 0; m_row = 0; end
            else                          m_row++;
        end else begin
            if (lreq && !win_l) m_lost = (m_lost < STARVE_LIMIT) ? m_lost + 1 : STARVE_LIMIT;
            else                m_lost = 0;
            if (fl) begin m_sweep = 1; m_row = 0; end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 4'h0, 0, 0);
    endtask

    task automatic random_cycles(input int n, input int p_lkp, input int p_upd, input int p_dbg, input int p_fl);
        for (int i = 0; i < n; i++) begin
            apply_stimulus($urandom_range(99) < p_lkp, $urandom_range(NR_ROWS-1),
                           $urandom_range(99) < p_upd, $urandom_range(NR_ROWS-1),
                           4'($urandom_range(15)), $urandom_range(99) < p_dbg,
                           $urandom_range(999) < p_fl);
        end
    endtask

    initial begin
        $display("[TB] starting bht_ram_arbiter bench");
        do_reset();
        // Init sweep plus first RUN cycle
        idle_cycles(NR_ROWS + 1);
        // Same-row update and lookup: update first, lookup next cycle sees new value
        apply_stimulus(1, 3, 1, 3, 4'hA, 0, 0);
        apply_stimulus(1, 3, 0, 0, 4'h0, 0, 0);
        idle_cycles(2);
        // Held lookup and update exercise the starvation guard
        for (int i = 0; i < 15; i++) apply_stimulus(1, i, 1, 63 - i, 4'(i), 0, 0);
        // Debug mode swallows updates
        for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 1, i, 4'hF, 1, 0);
        for (int i = 0; i < 6; i++) apply_stimulus(1, i, 0, 0, 4'h0, 0, 0);
        // Flush sweep with three dropped updates and a restart at row 20
        apply_stimulus(1, 7, 0, 0, 4'h0, 0, 1);
        for (int i = 0; i < 20; i++) apply_stimulus(0, 0, (i < 3), i, 4'h9, 0, 0);
        apply_stimulus(0, 0, 0, 0, 4'h0, 0, 1);
        idle_cycles(NR_ROWS + 2);
        // Randomized traffic
        random_cycles(1500, 70, 60, 10, 8);
        random_cycles(300, 100, 100, 0, 0);
        // Mid-run reset, then more traffic
        random_cycles(30, 50, 50, 10, 0);
        do_reset();
        random_cycles(800, 60, 60, 15, 10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
